// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit: one bit per cycle (shift-add multiply, restoring divide),
// fixed WIDTH-cycle latency, results held until the next completion.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             exception
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div, is_sgn, neg_q, neg_r, div0, exc_pend;
  logic [WIDTH-1:0] a_raw, b_reg, hi, lo, hi_nxt, lo_nxt;

  logic             accept, last;
  logic             a_neg, b_neg, in_div0, in_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign ready        = (state == IDLE) || (state == DONE);
  assign busy         = (state == RUN);
  assign result_valid = (state == DONE);
  assign accept       = start && ready && !kill;
  assign last         = (state == RUN) && (cnt == CW'(WIDTH-1));

  // Operand preparation: the datapath always works on magnitudes.
  assign a_neg   = !op[1] && operand_a[WIDTH-1];
  assign b_neg   = !op[1] && operand_b[WIDTH-1];
  assign a_mag   = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
  assign b_mag   = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;
  assign in_div0 = op[0] && (operand_b == '0);
  assign in_ovf  = op[0] && !op[1] && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (operand_b == '1);

  // One iteration. Multiply: {hi,lo} accumulates and shifts right, lo holds the multiplier.
  // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
  logic [WIDTH:0] sum, shifted, diff;
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, b_reg};
    if (is_div) begin
      hi_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], !diff[WIDTH]};
    end else begin
      {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's value.
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s, fin_lo, fin_hi;
  logic               fin_exc;
  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
    q_s    = neg_q ? (~lo_nxt + WIDTH'(1)) : lo_nxt;
    r_s    = neg_r ? (~hi_nxt + WIDTH'(1)) : hi_nxt;
    fin_lo  = prod_s[WIDTH-1:0];
    fin_hi  = prod_s[2*WIDTH-1:WIDTH];
    fin_exc = is_sgn ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}}) : (fin_hi != '0);
    if (is_div) begin
      fin_lo  = div0 ? '0 : q_s;
      fin_hi  = div0 ? a_raw : r_s;
      fin_exc = exc_pend;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (kill) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_sgn    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      exc_pend  <= 1'b0;
      a_raw     <= '0;
      b_reg     <= '0;
      hi        <= '0;
      lo        <= '0;
      result    <= '0;
      result_hi <= '0;
      exception <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= '0;
        is_div   <= op[0];
        is_sgn   <= !op[1];
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div0     <= in_div0;
        exc_pend <= in_div0 || in_ovf;
        a_raw    <= operand_a;
        b_reg    <= op[0] ? b_mag : a_mag;
        hi       <= '0;
        lo       <= op[0] ? a_mag : b_mag;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        hi  <= hi_nxt;
        lo  <= lo_nxt;
      end
      // A kill on the final iteration must leave the previous result visible.
      if (last && !kill) begin
        result    <= fin_lo;
        result_hi <= fin_hi;
        exception <= fin_exc;
      end
    end
  end
endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (even, >= 4).
REQ-002 SHALL have port: clock  input  1  master clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port: start  input  1  request a new operation; accepted only when ready=1 and kill=0.
REQ-005 SHALL have port: op  input  2  op[0]: 0=multiply, 1=divide; op[1]: 0=signed, 1=unsigned.
REQ-006 SHALL have port: operand_a  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port: operand_b  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port: kill  input  1  pipeline flush; aborts the in-flight operation.
REQ-009 SHALL have port: ready  output  1  unit can accept start this cycle.
REQ-010 SHALL have port: busy  output  1  operation in flight; drives pipeline stall.
REQ-011 SHALL have port: result_valid  output  1  one-cycle pulse, result/result_hi/exception valid.
REQ-012 SHALL have port: result  output  WIDTH  product low half or quotient.
REQ-013 SHALL have port: result_hi  output  WIDTH  product high half or remainder.
REQ-014 SHALL have port: exception  output  1  overflow / divide-by-zero flag, qualified by result_valid.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; ready=1 in IDLE and DONE, busy=1 only in RUN, result_valid=1 only in DONE.
REQ-016 SHALL, on an edge with start=1, ready=1, kill=0, latch op, operand magnitudes and sign flags, clear iteration counter, enter RUN.
REQ-017 SHALL perform exactly one iteration per RUN cycle (shift-add multiply, restoring divide), 1 bit per cycle, fixed latency independent of operand values.
REQ-018 SHALL enter DONE on the edge completing iteration WIDTH: start accepted at edge E0 -> result_valid high between edges E(WIDTH) and E(WIDTH+1).
REQ-019 SHALL leave DONE after one cycle: to RUN if a new start is accepted on that edge (back-to-back), else IDLE.
REQ-020 SHALL hold result, result_hi, exception stable from DONE until the next DONE; start alone SHALL NOT alter them.
REQ-021 SHALL produce, for multiply, the full 2*WIDTH product: result=low half, result_hi=high half (two's complement if signed).
REQ-022 SHALL set exception on signed multiply when result_hi is not the sign extension of result[WIDTH-1]; on unsigned multiply when result_hi != 0.
REQ-023 SHALL produce, for divide, quotient truncated toward zero in result and remainder with sign of dividend in result_hi.
REQ-024 SHALL, for divisor 0 (signed or unsigned), return result=0, result_hi=operand_a, exception=1, with normal latency.
REQ-025 SHALL, for signed divide of most-negative value by -1, return result=most-negative value, result_hi=0, exception=1.
REQ-026 SHALL, when kill=1 in RUN or DONE, go to IDLE on the next edge, suppress result_valid, leave result/result_hi/exception unchanged.
REQ-027 SHALL discard start when kill=1 on the same edge (kill priority); kill in IDLE SHALL have no effect.
REQ-028 SHALL ignore start, op and operands while in RUN.

Reset
REQ-029 SHALL, while reset=0, immediately force state IDLE, counter 0, result=0, result_hi=0, exception=0, result_valid=0, busy=0, ready=1.
REQ-030 SHALL abort any in-flight operation on reset with no result_valid pulse after reset release.
REQ-031 SHALL accept a start on the first rising edge after reset returns to 1.

Verification (WIDTH=32)
REQ-032 SHALL verify: signed mul 7 x -3 -> result 0xFFFFFFEB, result_hi 0xFFFFFFFF, exception 0, result_valid exactly 32 edges after accepting edge, busy high 32 cycles.
REQ-033 SHALL verify: signed div -7/2 -> result 0xFFFFFFFD, result_hi 0xFFFFFFFF; unsigned div 0xFFFFFFFF/16 -> result 0x0FFFFFFF, result_hi 0xF.
REQ-034 SHALL verify: div 5/0 -> result 0, result_hi 5, exception 1; signed 0x80000000/-1 -> result 0x80000000, result_hi 0, exception 1; signed mul 0x10000 x 0x10000 -> result 0, result_hi 1, exception 1.
REQ-035 SHALL verify: kill asserted 10 cycles into RUN -> no result_valid, ready=1 next cycle, prior result held; following mul 3x4 -> result 12.
REQ-036 SHALL verify: back-to-back start during DONE -> second result_valid exactly 33 edges after first, both results correct.
REQ-037 SHALL verify: reset=0 mid-RUN -> outputs zero asynchronously before next edge, no result_valid after release, start accepted on first edge.
